// File: rtl/decode_execute_reg.sv
// ID/EX pipeline register: captures decode controls/operands, holds on stall, zeroes on flush.
// Latency 1 cycle D->E; PCsrcE is resolved combinationally from E registers and ALU flags.
module decode_execute_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int CONTROL_WIDTH  = 3,
  parameter int IMM_WIDTH      = 2,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      EnE,
  input  logic                      FlushE,
  input  logic [2:0]                RegWriteD,
  input  logic [1:0]                MemWriteD,
  input  logic [IMM_WIDTH-1:0]      ResultsrcD,
  input  logic [CONTROL_WIDTH-1:0]  ALUctrlD,
  input  logic                      ALUsrcD,
  input  logic                      JumpD,
  input  logic                      JalrD,
  input  logic                      BranchD,
  input  logic [2:0]                funct3D,
  input  logic [DATA_WIDTH-1:0]     RD1D,
  input  logic [DATA_WIDTH-1:0]     RD2D,
  input  logic [DATA_WIDTH-1:0]     PCD,
  input  logic [DATA_WIDTH-1:0]     PCPlus4D,
  input  logic [DATA_WIDTH-1:0]     ImmExtD,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  input  logic                      ZeroE,
  input  logic                      LtE,
  input  logic                      LtuE,
  output logic [2:0]                RegWriteE,
  output logic [1:0]                MemWriteE,
  output logic [IMM_WIDTH-1:0]      ResultsrcE,
  output logic [CONTROL_WIDTH-1:0]  ALUctrlE,
  output logic                      ALUsrcE,
  output logic                      JumpE,
  output logic                      JalrE,
  output logic                      BranchE,
  output logic [2:0]                funct3E,
  output logic [DATA_WIDTH-1:0]     RD1E,
  output logic [DATA_WIDTH-1:0]     RD2E,
  output logic [DATA_WIDTH-1:0]     PCE,
  output logic [DATA_WIDTH-1:0]     PCPlus4E,
  output logic [DATA_WIDTH-1:0]     ImmExtE,
  output logic [REG_ADDR_WIDTH-1:0] Rs1E,
  output logic [REG_ADDR_WIDTH-1:0] Rs2E,
  output logic [REG_ADDR_WIDTH-1:0] RdE,
  output logic                      ValidE,
  output logic [1:0]                PCsrcE
);

  typedef struct packed {
    logic [2:0]                reg_write;
    logic [1:0]                mem_write;
    logic [IMM_WIDTH-1:0]      result_src;
    logic [CONTROL_WIDTH-1:0]  alu_ctrl;
    logic                      alu_src;
    logic                      jump;
    logic                      jalr;
    logic                      branch;
    logic [2:0]                funct3;
    logic [DATA_WIDTH-1:0]     rd1;
    logic [DATA_WIDTH-1:0]     rd2;
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     pc_plus4;
    logic [DATA_WIDTH-1:0]     imm_ext;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } ex_t;

  ex_t  ex_in;
  ex_t  ex_d, ex_q;
  logic valid_d, valid_q;
  logic taken;

  always_comb begin
    ex_in.reg_write  = RegWriteD;
    ex_in.mem_write  = MemWriteD;
    ex_in.result_src = ResultsrcD;
    ex_in.alu_ctrl   = ALUctrlD;
    ex_in.alu_src    = ALUsrcD;
    ex_in.jump       = JumpD;
    ex_in.jalr       = JalrD;
    ex_in.branch     = BranchD;
    ex_in.funct3     = funct3D;
    ex_in.rd1        = RD1D;
    ex_in.rd2        = RD2D;
    ex_in.pc         = PCD;
    ex_in.pc_plus4   = PCPlus4D;
    ex_in.imm_ext    = ImmExtD;
    ex_in.rs1        = Rs1D;
    ex_in.rs2        = Rs2D;
    ex_in.rd         = RdD;
  end

  // Flush beats stall beats load; a bubble is the all-zero word.
  always_comb begin
    ex_d    = ex_q;
    valid_d = valid_q;
    if (FlushE) begin
      ex_d    = '0;
      valid_d = 1'b0;
    end else if (EnE) begin
      ex_d    = ex_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      ex_q    <= ex_d;
      valid_q <= valid_d;
    end
  end

  assign RegWriteE  = ex_q.reg_write;
  assign MemWriteE  = ex_q.mem_write;
  assign ResultsrcE = ex_q.result_src;
  assign ALUctrlE   = ex_q.alu_ctrl;
  assign ALUsrcE    = ex_q.alu_src;
  assign JumpE      = ex_q.jump;
  assign JalrE      = ex_q.jalr;
  assign BranchE    = ex_q.branch;
  assign funct3E    = ex_q.funct3;
  assign RD1E       = ex_q.rd1;
  assign RD2E       = ex_q.rd2;
  assign PCE        = ex_q.pc;
  assign PCPlus4E   = ex_q.pc_plus4;
  assign ImmExtE    = ex_q.imm_ext;
  assign Rs1E       = ex_q.rs1;
  assign Rs2E       = ex_q.rs2;
  assign RdE        = ex_q.rd;
  assign ValidE     = valid_q;

  always_comb begin
    taken = 1'b0;
    case (ex_q.funct3)
      3'b000:  taken = ZeroE;
      3'b001:  taken = ~ZeroE;
      3'b100:  taken = LtE;
      3'b101:  taken = ~LtE;
      3'b110:  taken = LtuE;
      3'b111:  taken = ~LtuE;
      default: taken = 1'b0;
    endcase
  end

  // JALR targets come from the ALU, so it outranks the PC-relative redirects.
  always_comb begin
    PCsrcE = 2'b00;
    if (valid_q) begin
      if (ex_q.jalr)
        PCsrcE = 2'b10;
      else if (ex_q.jump)
        PCsrcE = 2'b01;
      else if (ex_q.branch && taken)
        PCsrcE = 2'b01;
    end
  end

endmodule

// File: tb/tb_decode_execute_reg.sv
// Randomised and directed bench for decode_execute_reg against a snapshot model of the D inputs.
module tb_decode_execute_reg;

  logic        clk, rst_n, EnE, FlushE;
  logic [2:0]  RegWriteD, funct3D;
  logic [1:0]  MemWriteD, ResultsrcD;
  logic [2:0]  ALUctrlD;
  logic        ALUsrcD, JumpD, JalrD, BranchD;
  logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        ZeroE, LtE, LtuE;
  logic [2:0]  RegWriteE, funct3E, ALUctrlE;
  logic [1:0]  MemWriteE, ResultsrcE;
  logic        ALUsrcE, JumpE, JalrE, BranchE, ValidE;
  logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [1:0]  PCsrcE;

  decode_execute_reg dut (
    .clk(clk), .rst_n(rst_n), .EnE(EnE), .FlushE(FlushE),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ResultsrcD(ResultsrcD),
    .ALUctrlD(ALUctrlD), .ALUsrcD(ALUsrcD), .JumpD(JumpD), .JalrD(JalrD),
    .BranchD(BranchD), .funct3D(funct3D), .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultsrcE(ResultsrcE),
    .ALUctrlE(ALUctrlE), .ALUsrcE(ALUsrcE), .JumpE(JumpE), .JalrE(JalrE),
    .BranchE(BranchE), .funct3E(funct3E), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ValidE(ValidE), .PCsrcE(PCsrcE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [191:0] d_vec, e_vec;
  assign d_vec = {RegWriteD, MemWriteD, ResultsrcD, ALUctrlD, ALUsrcD, JumpD, JalrD, BranchD,
                  funct3D, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD};
  assign e_vec = {RegWriteE, MemWriteE, ResultsrcE, ALUctrlE, ALUsrcE, JumpE, JalrE, BranchE,
                  funct3E, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE};

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: E holds a snapshot of whatever D looked like at the last loading edge.
  logic [191:0] m_vec;
  logic         m_valid, m_jalr, m_jump, m_branch;
  logic [2:0]   m_f3;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || FlushE) begin
      m_vec = '0; m_valid = 0; m_jalr = 0; m_jump = 0; m_branch = 0; m_f3 = 0;
    end else if (EnE) begin
      m_vec = d_vec; m_valid = 1; m_jalr = JalrD; m_jump = JumpD;
      m_branch = BranchD; m_f3 = funct3D;
    end
  end

  function automatic logic [1:0] model_pcsrc(input logic z, input logic lt, input logic ltu);
    logic [7:0] cond_tbl;
    cond_tbl = {~ltu, ltu, ~lt, lt, 1'b0, 1'b0, ~z, z};
    if (!m_valid) return 2'b00;
    if (m_jalr)   return 2'b10;
    if (m_jump)   return 2'b01;
    if (m_branch && cond_tbl[m_f3]) return 2'b01;
    return 2'b00;
  endfunction

  logic run_cmp = 1'b0;
  always @(negedge clk) begin
    if (run_cmp) begin
      check("model_eregs", e_vec, m_vec);
      check("model_valid", 192'(ValidE), 192'(m_valid));
      check("model_pcsrc", 192'(PCsrcE), 192'(model_pcsrc(ZeroE, LtE, LtuE)));
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_d();
    {RegWriteD, MemWriteD, ResultsrcD, ALUctrlD, ALUsrcD, JumpD, JalrD, BranchD,
     funct3D, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD} = '0;
  endtask

  task automatic rand_d();
    RegWriteD = 3'($urandom); MemWriteD = 2'($urandom); ResultsrcD = 2'($urandom);
    ALUctrlD = 3'($urandom); ALUsrcD = 1'($urandom);
    JumpD = ($urandom_range(0, 4) == 0); JalrD = ($urandom_range(0, 5) == 0);
    BranchD = ($urandom_range(0, 2) == 0); funct3D = 3'($urandom);
    RD1D = $urandom; RD2D = $urandom; PCD = $urandom; PCPlus4D = $urandom; ImmExtD = $urandom;
    Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
  endtask

  initial begin
    rst_n = 0; EnE = 0; FlushE = 0; ZeroE = 0; LtE = 0; LtuE = 0;
    rand_d();
    #3;
    check("reset_eregs", e_vec, '0);
    check("reset_valid", 192'(ValidE), 192'(0));
    check("reset_pcsrc", 192'(PCsrcE), 192'(0));
    @(negedge clk); #1;
    rst_n = 1; run_cmp = 1;

    // Plain load.
    clear_d(); RD1D = 32'h1234; RdD = 5'd5; RegWriteD = 3'b001; EnE = 1;
    cyc();
    check("load_rd1", 192'(RD1E), 192'(32'h1234));
    check("load_rd", 192'(RdE), 192'(5));
    check("load_regwrite", 192'(RegWriteE), 192'(3'b001));
    check("load_valid", 192'(ValidE), 192'(1));

    // Stall three edges while D churns.
    #1; EnE = 0;
    for (int i = 0; i < 3; i++) begin
      rand_d();
      cyc();
      check("stall_rd1", 192'(RD1E), 192'(32'h1234));
      check("stall_valid", 192'(ValidE), 192'(1));
      #1;
    end
    clear_d(); RD1D = 32'hBEEF; EnE = 1;
    cyc();
    check("unstall_rd1", 192'(RD1E), 192'(32'hBEEF));

    // Flush takes priority over stall.
    #1; MemWriteD = 2'b01; FlushE = 1; EnE = 0;
    cyc();
    check("flush_memwrite", 192'(MemWriteE), 192'(0));
    check("flush_valid", 192'(ValidE), 192'(0));
    check("flush_pcsrc", 192'(PCsrcE), 192'(0));

    // Branch resolution.
    #1; clear_d(); FlushE = 0; EnE = 1; BranchD = 1; funct3D = 3'b001; ZeroE = 0;
    cyc();
    check("bne_taken", 192'(PCsrcE), 192'(2'b01));
    #1; ZeroE = 1; #1;
    check("bne_not_taken", 192'(PCsrcE), 192'(2'b00));
    funct3D = 3'b110; LtuE = 1;
    cyc();
    check("bltu_taken", 192'(PCsrcE), 192'(2'b01));

    // Jumps.
    #1; clear_d(); JalrD = 1; JumpD = 1;
    cyc();
    check("jalr_wins", 192'(PCsrcE), 192'(2'b10));
    #1; JalrD = 0;
    cyc();
    check("jal", 192'(PCsrcE), 192'(2'b01));
    #1; FlushE = 1;
    cyc();
    check("jal_flushed", 192'(PCsrcE), 192'(2'b00));

    // Reset during a stall: outputs clear immediately and stay clear until release.
    #1; FlushE = 0; EnE = 1; rand_d(); JumpD = 1;
    cyc();
    #1; EnE = 0; rst_n = 0; #1;
    check("midreset_eregs", e_vec, '0);
    check("midreset_valid", 192'(ValidE), 192'(0));
    EnE = 1;
    cyc();
    check("reset_held_valid", 192'(ValidE), 192'(0));
    #1; rst_n = 1; rand_d();
    cyc();
    check("post_reset_load", e_vec, d_vec);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      #1;
      EnE    = ($urandom_range(0, 3) != 0);
      FlushE = ($urandom_range(0, 6) == 0);
      ZeroE  = 1'($urandom); LtE = 1'($urandom); LtuE = 1'($urandom);
      rand_d();
      cyc();
    end

    run_cmp = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
